// File: rtl/fifo_pkg.sv
// Shared constants for the dual-clock 32-bit FIFO and its front ends.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_DEPTH      = 16;
    localparam int BYTE_W          = 8;

    // Number of byte lanes in a word of width dw built from bw-bit bytes.
    function automatic int lanes_f(input int dw, input int bw);
        return dw / bw;
    endfunction

    localparam int LANES_C = lanes_f(FIFO_DATA_WIDTH, BYTE_W);

endpackage

// File: rtl/fifo_w_byte_packer.sv
// Write-domain byte packer: gathers a valid/ready byte stream little-endian
// into FIFO words, padding and flushing partial words on s_last_i or after
// an idle timeout, and writes them through a single output register.
//
// Handshake: a byte moves on every rising clk_w_i edge where s_valid_i and
// s_ready_o are both high; s_data_i/s_last_i are only sampled on that edge.
// s_ready_o depends only on the output register and full_i, never on
// s_valid_i. The FIFO side has no ready: wen_o is a one-cycle write strobe
// that is never raised while full_i is high.
module fifo_w_byte_packer
    import fifo_pkg::*;
#(
    parameter int                DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int                BYTE_W        = 8,
    parameter logic [BYTE_W-1:0] PAD_BYTE      = '0,
    parameter int                FLUSH_TIMEOUT = 64,
    parameter int                CNT_WIDTH     = 16
) (
    input  logic                  clk_w_i,
    input  logic                  rst_w_an_i,
    input  logic                  s_valid_i,
    input  logic [BYTE_W-1:0]     s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    input  logic                  full_i,
    output logic                  wen_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  partial_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
);

    localparam int LANES = lanes_f(DATA_WIDTH, BYTE_W);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);
    localparam logic          TO_EN     = (FLUSH_TIMEOUT > 0);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  pend_q, pend_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

    logic                  accept;
    logic                  completing;
    logic                  flush_hit;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] byte_word;
    logic [DATA_WIDTH-1:0] flush_word;

    // The output register is free when empty or draining in this cycle.
    assign wen_o      = pend_q & ~full_i;
    assign s_ready_o  = ~pend_q | ~full_i;
    assign wdata_o    = out_q;
    assign partial_o  = (lane_q != '0);
    assign word_cnt_o = word_cnt_q;

    // Build the merged accumulator and both padded candidate words.
    always_comb begin
        merged     = acc_q;
        byte_word  = acc_q;
        flush_word = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (LW'(i) == lane_q) begin
                merged[i*BYTE_W +: BYTE_W]     = s_data_i;
                byte_word[i*BYTE_W +: BYTE_W]  = s_data_i;
                flush_word[i*BYTE_W +: BYTE_W] = PAD_BYTE;
            end else if (LW'(i) > lane_q) begin
                byte_word[i*BYTE_W +: BYTE_W]  = PAD_BYTE;
                flush_word[i*BYTE_W +: BYTE_W] = PAD_BYTE;
            end
        end
    end

    // Next-state logic: byte accept has priority over the idle flush.
    always_comb begin
        accept     = s_valid_i & s_ready_o;
        completing = accept & (s_last_i | (lane_q == LANE_LAST));
        flush_hit  = TO_EN & ~accept & (lane_q != '0) &
                     (idle_q == IDLE_MAX) & s_ready_o;

        acc_d      = acc_q;
        lane_d     = lane_q;
        out_d      = out_q;
        pend_d     = pend_q;
        idle_d     = idle_q;
        word_cnt_d = word_cnt_q;

        if (wen_o) begin
            pend_d     = 1'b0;
            word_cnt_d = word_cnt_q + 1'b1;
        end

        if (completing) begin
            out_d  = byte_word;
            pend_d = 1'b1;
            lane_d = '0;
            acc_d  = '0;
            idle_d = '0;
        end else if (accept) begin
            acc_d  = merged;
            lane_d = lane_q + 1'b1;
            idle_d = '0;
        end else if (flush_hit) begin
            out_d  = flush_word;
            pend_d = 1'b1;
            lane_d = '0;
            acc_d  = '0;
            idle_d = '0;
        end else if (!TO_EN || lane_q == '0) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously so a reset drops wen_o at once.
    always_ff @(posedge clk_w_i or negedge rst_w_an_i) begin
        if (!rst_w_an_i) begin
            acc_q      <= '0;
            lane_q     <= '0;
            out_q      <= '0;
            pend_q     <= 1'b0;
            idle_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            lane_q     <= lane_d;
            out_q      <= out_d;
            pend_q     <= pend_d;
            idle_q     <= idle_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: doc/fifo_w_byte_packer.md
Name: fifo_w_byte_packer

Overview:
- Write-domain front end for the team's dual-clock 32-bit FIFO.
- Accepts an 8-bit valid/ready byte stream and packs bytes little-endian into DATA_WIDTH words.
- Drives the FIFO write port (wen/wdata) and honours the FIFO full flag.
- Partial words are padded and flushed on s_last_i or after an idle timeout, so no byte is stranded.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be a multiple of BYTE_W.
- BYTE_W, 8, input byte width.
- PAD_BYTE, 8'h00, value placed in unfilled lanes on a flush.
- FLUSH_TIMEOUT, 64, idle cycles before a partial word is flushed; 0 disables the timeout.
- CNT_WIDTH, 16, width of the written-word counter.

Ports:
- clk_w_i  in  1  write-domain clock.
- rst_w_an_i  in  1  reset; asynchronous, active-low.
- s_valid_i  in  1  input byte valid.
- s_data_i  in  BYTE_W  input byte.
- s_last_i  in  1  final byte of a packet; forces a word flush.
- s_ready_o  out  1  byte accepted when s_valid_i & s_ready_o.
- full_i  in  1  FIFO full; no write while high.
- wen_o  out  1  FIFO write enable; connects to FIFO wen_i.
- wdata_o  out  DATA_WIDTH  FIFO write data; connects to FIFO wdata_i.
- partial_o  out  1  accumulator holds 1..LANES-1 bytes.
- word_cnt_o  out  CNT_WIDTH  words written since reset, wrapping.

Behaviour:
- LANES = DATA_WIDTH/BYTE_W.
- State registers:
  - acc_r: DATA_WIDTH accumulator.
  - lane_r: 0..LANES-1.
  - out_r: DATA_WIDTH output word.
  - pend_r: out_r valid.
  - idle_r: timeout counter.
  - word_cnt_r.
- Reset (async, while rst_w_an_i=0):
  - All registers are 0; acc_r and out_r are also 0.
  - Outputs during reset: wen_o=0, s_ready_o=1, partial_o=0, word_cnt_o=0, wdata_o=0.
- Combinational outputs:
  - wen_o = pend_r & ~full_i.
  - wdata_o = out_r, held stable while pend_r=1.
  - s_ready_o = ~pend_r | ~full_i, i.e. the output register is free or is draining this cycle.
  - partial_o = (lane_r != 0).
- Byte accept:
  - The byte is written into lane lane_r, so the first byte lands in bits [BYTE_W-1:0].
  - If lane_r < LANES-1 and s_last_i=0: lane_r increments and idle_r clears.
  - If lane_r = LANES-1 or s_last_i=1 (completing byte):
    - out_r <= acc with this byte merged, and unfilled upper lanes set to PAD_BYTE.
    - pend_r <= 1.
    - lane_r <= 0, acc_r cleared, idle_r cleared.
- Drain:
  - On a wen_o cycle, word_cnt_r increments (wraps at 2^CNT_WIDTH).
  - pend_r clears unless a completing byte or a flush reloads out_r in the same cycle; a reload keeps pend_r=1 (back-to-back writes).
- Latency: wen_o asserts in the cycle after the completing byte is accepted, if full_i=0. Sustained throughput is 1 byte/cycle, i.e. 1 word per LANES cycles.
- Timeout, when FLUSH_TIMEOUT > 0:
  - idle_r increments each cycle that lane_r != 0 and no byte is accepted; it saturates at FLUSH_TIMEOUT.
  - When idle_r = FLUSH_TIMEOUT and (~pend_r | wen_o):
    - out_r <= acc_r with empty lanes padded; pend_r <= 1.
    - lane_r <= 0, idle_r <= 0.
  - While the output register is blocked, the flush waits and idle_r stays saturated.
- Simultaneous events:
  - An accepted byte in the timeout cycle takes priority: the byte is merged and idle_r clears.
  - s_last_i on the byte that fills lane LANES-1 produces exactly one word, with no extra padded word.
- Full:
  - While full_i=1 and pend_r=1: wen_o=0, s_ready_o=0, and out_r, acc_r and lane_r are unchanged.
  - No write is ever issued with full_i=1.
- full_i is treated as same-cycle truthful. The FIFO's full flag must be conservative.
- Reset mid-operation: the partial word and pending word are discarded, and wen_o drops immediately (asynchronously).

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_DATA_WIDTH = 32, FIFO_DEPTH = 16.
  - BYTE_W = 8.
  - LANES_C, a function of the data width.
- Same package as the FIFO core.
- Single module; no sub-module is required. The timeout counter is small enough to stay inline.

Test Plan:
- Bytes 11,22,33,44 on consecutive cycles, full_i=0 -> single wen_o pulse one cycle after byte 44, wdata_o=0x44332211, word_cnt_o=1.
- Bytes AA,BB with s_last_i on BB -> wen_o with wdata_o=0x0000BBAA; partial_o=0 afterwards.
- 8 bytes 01..08 with full_i=1 from the cycle the first word pends, released after 10 cycles -> s_ready_o=0 and wen_o=0 while full; then writes 0x04030201 and 0x08070605 in order, no loss, no duplicates.
- Single byte 5A then idle -> wen_o with wdata_o=0x0000005A exactly FLUSH_TIMEOUT+1 cycles after accept; a byte arriving at cycle 63 instead cancels the flush.
- Bytes 11,22 then rst_w_an_i pulsed low -> wen_o=0, partial_o=0, word_cnt_o=0. Next bytes 33,44,55,66 -> wdata_o=0x66554433.
- 2^CNT_WIDTH+1 full words streamed -> word_cnt_o wraps to 1.
